rv_timer: RTL and testbench
===========================

// Module: rv_timer
// PURPOSE
//  Memory-mapped 32-bit prescaled timer/compare peripheral on the CPU d_* bus at ffff0080 (cs decoded by top).
//  Read data joins the d_dr OR-tree; irq is ORed with the rv_sio irq toward rv_core.
//  Provides periodic/one-shot tick interrupts for firmware.
// PARAMETERS
//  CNT_W    32  counter/compare width, 8..32; upper register bits read 0, writes ignored
//  PRESC_W  16  prescaler width, 1..16; lives in CTRL[16+PRESC_W-1:16]
// PORTS
//  clk     in   1   CPU bus clock (cclk); single clock domain
//  reset   in   1   synchronous, active-high reset
//  adr     in   5   byte offset within the 32-byte window (d_adr[4:0])
//  cs      in   1   window select
//  rdy     in   1   bus ready; an access takes effect only when cs&rdy
//  we      in   4   byte write enables; we[i] writes dw[8i+7:8i]
//  re      in   1   read enable
//  dw      in   32  write data
//  dr      out  32  registered read data; 0 when not read
//  irq     out  1   level interrupt = CTRL.IE & STAT.MATCH
//  cap_in  in   1   async capture input (present only with RV_TIMER_CAPTURE_EN)
// BEHAVIOUR
//  Register map (little endian; big-endian bus mode is not supported):
//   00 CTRL  [0]EN [1]AUTO (reload 0 on match) [2]IE [3]CLR (W1, self-clearing, reads 0) [16+:PRESC_W]PRESC
//   04 COUNT r/w    08 CMP r/w (reset FFFF_FFFF)
//   0C STAT  [0]MATCH [1]OVF [2]CAPF; all sticky, write-1-to-clear
//   10 CAP   read-only capture value; 14..1C read 0, writes ignored
//  Reset: CTRL=0, COUNT=0, CMP=all ones, STAT=0, CAP=0, pcnt=0, dr=0, irq=0.
//  Read: when cs&rdy&re in cycle N, dr holds the selected register in N+1. Otherwise dr=0.
//   A read and a write in the same cycle return the pre-write value.
//  Prescaler: pcnt counts 0..PRESC while EN=1. tick=EN&(pcnt==PRESC).
//   pcnt clears on tick, when EN=0, and on any write to the PRESC bytes. PRESC=0 gives a tick every clk.
//  On tick:
//   COUNT==CMP: set MATCH. If AUTO=1, COUNT<=0; else COUNT<=COUNT+1.
//   COUNT==max (all ones, CNT_W bits) and not reloaded: COUNT<=0 and set OVF.
//  Priority for COUNT, highest first: CPU write to COUNT bytes, then CLR, then tick.
//   A byte write merges into the current value; there is no increment that cycle.
//  STAT: a hardware set in the same cycle as a W1C of the same bit leaves the bit set (set wins).
//  CMP write: does not itself set MATCH; the comparison uses the new CMP from the next cycle.
//  irq is combinational from the registered IE and MATCH; it deasserts the cycle after the W1C.
//  EN 1->0 freezes COUNT; an edge on 0->1 restarts the prescaler at 0.
//  Reset asserted mid-count returns every register to its reset value on the next clk edge.
// CONFIGURATION
//  RV_TIMER_CAPTURE_EN defined:
//   - cap_in passes through a 2-FF synchronizer with rising-edge detect.
//   - On an edge, CAP<=COUNT (value before any same-cycle update) and CAPF is set.
//   - Edges while CAPF=1 still overwrite CAP.
//   - Synchronizer latency is 3 clk from the cap_in edge to CAP valid.
//  Undefined:
//   - There is no cap_in port.
//   - CAP and CAPF read 0 and writes to them are ignored.
// STRUCTURE
//  Existing rv_types.svh: u32_t, u8_t, u4_t.
//  rv_timer_pkg: register offset localparams (TMR_CTRL..TMR_CAP), ctrl_t packed struct, STAT bit indices.
//  One sub-module, rv_timer_sync: 2-FF synchronizer plus rising-edge pulse. Instantiated only under RV_TIMER_CAPTURE_EN.
// TESTING
//  1 Reset, then read every offset: CMP=FFFF_FFFF, all others 0, dr=0 on idle cycles, irq=0.
//  2 PRESC=3, CMP=5, AUTO=1, IE=1, EN=1:
//    - irq asserts when COUNT==5 at its 6th tick (24 clk after EN).
//    - COUNT returns to 0.
//    - W1C of MATCH drops irq next cycle.
//  3 COUNT=FFFF_FFFE, PRESC=0, AUTO=0, EN=1: after 2 clk COUNT=0 and OVF=1.
//    Byte write we=0001, dw=AA gives COUNT[7:0]=AA with the other bytes unchanged.
//  4 Simultaneous events:
//    - COUNT write in the same cycle as a tick: the written value wins.
//    - MATCH set in the same cycle as a W1C: MATCH stays 1.
//  5 Read latency and reset mid-operation:
//    - re on COUNT returns the pre-write value when combined with a write.
//    - Reset asserted mid-count clears everything next clk.
//  6 With RV_TIMER_CAPTURE_EN: pulse cap_in while COUNT=100 with PRESC=0, then after 3 clk CAP=COUNT at the sync edge and CAPF=1.
//    Without the macro, CAP reads 0.

Source files
------------

// File: rtl/rv_timer_pkg.sv
// rv_timer_pkg: shared types, register offsets, CTRL layout and STAT bit
// indices for the rv_timer peripheral. The optional capture path is built
// only when RV_TIMER_CAPTURE_EN is defined.
package rv_timer_pkg;

  typedef logic [31:0] u32_t;
  typedef logic [7:0]  u8_t;
  typedef logic [3:0]  u4_t;

  // Byte offsets inside the 32-byte window
  localparam logic [4:0] TMR_CTRL  = 5'h00;
  localparam logic [4:0] TMR_COUNT = 5'h04;
  localparam logic [4:0] TMR_CMP   = 5'h08;
  localparam logic [4:0] TMR_STAT  = 5'h0C;
  localparam logic [4:0] TMR_CAP   = 5'h10;

  // STAT bit positions
  localparam int STAT_MATCH = 0;
  localparam int STAT_OVF   = 1;
  localparam int STAT_CAPF  = 2;

  // CTRL register image, bit 0 in the last field
  typedef struct packed {
    logic [15:0] presc;
    logic [11:0] rsvd;
    logic        clr;
    logic        ie;
    logic        auto_rl;
    logic        en;
  } ctrl_t;

  // Little-endian byte-lane merge of write data into an existing word
  function automatic u32_t bmerge(input u32_t old, input u32_t d, input u4_t be);
    u32_t r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/rv_timer_sync.sv
// rv_timer_sync: two-flop synchronizer for an asynchronous input followed by
// a rising-edge detector producing a one-clock pulse.
module rv_timer_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic s1, s2, s3;

  // Metastability chain plus one delayed copy for edge detect
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/rv_timer.sv
// rv_timer: memory-mapped prescaled 32-bit timer/compare peripheral.
// Registers CTRL/COUNT/CMP/STAT/CAP, registered read data, level irq.
// Define RV_TIMER_CAPTURE_EN to add the cap_in capture input, CAP and CAPF.
module rv_timer
  import rv_timer_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  adr,
  input  logic        cs,
  input  logic        rdy,
  input  logic [3:0]  we,
  input  logic        re,
  input  logic [31:0] dw,
`ifdef RV_TIMER_CAPTURE_EN
  input  logic        cap_in,
`endif
  output logic [31:0] dr,
  output logic        irq
);

  localparam u32_t        CNT_MAX    = u32_t'({CNT_W{1'b1}});
  localparam logic [15:0] PRESC_MASK = 16'({PRESC_W{1'b1}});
  // PRESC reaches into byte 3 only when it is wider than 8 bits
  localparam logic        PRESC_HI   = (PRESC_W > 8);

  // Architectural state
  logic        en_q, auto_q, ie_q;
  logic [15:0] presc_q;
  logic [15:0] pcnt;
  u32_t        count, cmp, cap_q;
  logic [2:0]  stat;

  // Bus decode
  logic       acc, wr_any, rd_en;
  logic [2:0] sel;
  logic       wr_ctrl, wr_count, wr_cmp, wr_stat;

  assign acc      = cs & rdy;
  assign wr_any   = acc & (|we);
  assign rd_en    = acc & re;
  assign sel      = adr[4:2];
  assign wr_ctrl  = wr_any & (sel == TMR_CTRL[4:2]);
  assign wr_count = wr_any & (sel == TMR_COUNT[4:2]);
  assign wr_cmp   = wr_any & (sel == TMR_CMP[4:2]);
  assign wr_stat  = wr_any & (sel == TMR_STAT[4:2]) & we[0];

  // CTRL as seen by the bus (CLR always reads 0) and its merged write value
  ctrl_t ctrl_rd, ctrl_wv;
  logic  presc_wr, clr;

  assign ctrl_rd  = '{presc: presc_q, rsvd: '0, clr: 1'b0, ie: ie_q,
                      auto_rl: auto_q, en: en_q};
  assign ctrl_wv  = ctrl_t'(bmerge(u32_t'(ctrl_rd), dw, we));
  assign presc_wr = wr_ctrl & (we[2] | (PRESC_HI & we[3]));
  assign clr      = wr_ctrl & ctrl_wv.clr;

  // Tick and compare conditions, all from registered state
  logic tick, hit, at_max, reload;

  assign tick   = en_q & (pcnt == presc_q);
  assign hit    = (count == cmp);
  assign at_max = (count == CNT_MAX);
  assign reload = auto_q & hit;

  // Capture path
  logic cap_pulse;

`ifdef RV_TIMER_CAPTURE_EN
  localparam logic [2:0] STAT_IMPL = 3'b111;

  rv_timer_sync u_cap_sync (
    .clk  (clk),
    .reset(reset),
    .d    (cap_in),
    .rise (cap_pulse)
  );

  // Latch COUNT as it stood before this cycle's update; later edges overwrite
  always_ff @(posedge clk) begin
    if (reset)          cap_q <= '0;
    else if (cap_pulse) cap_q <= count;
  end
`else
  localparam logic [2:0] STAT_IMPL = 3'b011;

  assign cap_pulse = 1'b0;
  assign cap_q     = '0;
`endif

  // COUNT next value: CPU write beats CLR beats tick
  u32_t count_d;

  always_comb begin
    count_d = count;
    if (tick) begin
      if (reload || at_max) count_d = '0;
      else                  count_d = (count + 32'd1) & CNT_MAX;
    end
    if (clr)      count_d = '0;
    if (wr_count) count_d = bmerge(count, dw, we) & CNT_MAX;
  end

  // STAT next value: hardware set wins over a same-cycle W1C
  logic [2:0] stat_set, stat_w1c, stat_d;

  always_comb begin
    stat_set             = '0;
    stat_set[STAT_MATCH] = tick & hit;
    stat_set[STAT_OVF]   = tick & at_max & ~reload;
    stat_set[STAT_CAPF]  = cap_pulse;
    stat_w1c             = wr_stat ? dw[2:0] : 3'b000;
    stat_d               = (stat_set | (stat & ~stat_w1c)) & STAT_IMPL;
  end

  // Read mux; sampled before any same-cycle write lands
  u32_t rd_val;

  always_comb begin
    rd_val = '0;
    case (sel)
      TMR_CTRL[4:2]:  rd_val = u32_t'(ctrl_rd);
      TMR_COUNT[4:2]: rd_val = count;
      TMR_CMP[4:2]:   rd_val = cmp;
      TMR_STAT[4:2]:  rd_val = {29'd0, stat};
      TMR_CAP[4:2]:   rd_val = cap_q;
      default:        rd_val = '0;
    endcase
  end

  // Register update: control, prescaler, counter, compare, status, read data
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q    <= 1'b0;
      auto_q  <= 1'b0;
      ie_q    <= 1'b0;
      presc_q <= '0;
      pcnt    <= '0;
      count   <= '0;
      cmp     <= CNT_MAX;
      stat    <= '0;
      dr      <= '0;
    end else begin
      if (wr_ctrl) begin
        en_q    <= ctrl_wv.en;
        auto_q  <= ctrl_wv.auto_rl;
        ie_q    <= ctrl_wv.ie;
        presc_q <= ctrl_wv.presc & PRESC_MASK;
      end
      if (!en_q || presc_wr || tick) pcnt <= '0;
      else                           pcnt <= pcnt + 16'd1;
      count <= count_d;
      if (wr_cmp) cmp <= bmerge(cmp, dw, we) & CNT_MAX;
      stat  <= stat_d;
      dr    <= rd_en ? rd_val : 32'd0;
    end
  end

  assign irq = ie_q & stat[STAT_MATCH];

  // Address bits below word granularity and reserved CTRL bits carry no state
  logic unused_bits;
  assign unused_bits = ^{adr[1:0], ctrl_wv.rsvd};

endmodule

// File: tb/tb_rv_timer.sv
// tb_rv_timer: directed bench for rv_timer with a read-data scoreboard.
// Honors RV_TIMER_CAPTURE_EN to exercise the capture input.
module tb_rv_timer;
  import rv_timer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  adr;
  logic        cs, rdy, re;
  logic [3:0]  we;
  logic [31:0] dw, dr;
  logic        irq;
`ifdef RV_TIMER_CAPTURE_EN
  logic        cap_in;
`endif

  rv_timer dut (
    .clk   (clk),
    .reset (reset),
    .adr   (adr),
    .cs    (cs),
    .rdy   (rdy),
    .we    (we),
    .re    (re),
    .dw    (dw),
`ifdef RV_TIMER_CAPTURE_EN
    .cap_in(cap_in),
`endif
    .dr    (dr),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle, called at a negedge; the following posedge is the access edge
  task automatic bus(input logic [4:0] a, input logic [3:0] w, input logic r,
                     input logic [31:0] d, input logic [31:0] e, input string tag);
    exp_t x;
    adr = a; we = w; re = r; dw = d; cs = 1'b1; rdy = 1'b1;
    if (r) begin
      x.tag = tag;
      x.v   = e;
      sbq.push_back(x);
    end
    @(negedge clk);
    cs = 1'b0; we = 4'h0; re = 1'b0; adr = 5'h0; dw = 32'h0;
    if (r) begin
      x = sbq.pop_front();
      chk(x.tag, dr, x.v);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [3:0] w, input logic [31:0] d);
    bus(a, w, 1'b0, d, 32'h0, "");
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e, input string tag);
    bus(a, 4'h0, 1'b1, 32'h0, e, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; adr = 0; cs = 0; rdy = 0; re = 0; we = 0; dw = 0;
`ifdef RV_TIMER_CAPTURE_EN
    cap_in = 1'b0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rdy   = 1'b1;

    // 1: reset values
    chk("rst_dr", dr, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    rd(TMR_CTRL,  32'h0,         "rst_ctrl");
    rd(TMR_COUNT, 32'h0,         "rst_count");
    rd(TMR_CMP,   32'hFFFF_FFFF, "rst_cmp");
    rd(TMR_STAT,  32'h0,         "rst_stat");
    rd(TMR_CAP,   32'h0,         "rst_cap");
    rd(5'h14,     32'h0,         "rst_r14");
    rd(5'h18,     32'h0,         "rst_r18");
    rd(5'h1C,     32'h0,         "rst_r1c");
    @(negedge clk);
    chk("idle_dr", dr, 32'h0);

    // 2: PRESC=3, CMP=5, AUTO/IE/EN -> irq 24 clk after enable
    wr(TMR_CMP, 4'hF, 32'd5);
    wr(TMR_CTRL, 4'hF, (32'd3 << 16) | 32'h7);
    n = 0;
    while (!irq && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("irq_latency", n, 32'd24);
    rd(TMR_COUNT, 32'h0, "auto_reload");
    chk("irq_high", {31'd0, irq}, 32'h1);
    wr(TMR_STAT, 4'h1, 32'h1);
    chk("irq_w1c", {31'd0, irq}, 32'h0);
    wr(TMR_CTRL, 4'hF, 32'h0);

    // 3: overflow at PRESC=0, then byte-lane write
    wr(TMR_COUNT, 4'hF, 32'hFFFF_FFFE);
    wr(TMR_CTRL, 4'hF, 32'h1);
    @(negedge clk);
    wr(TMR_CTRL, 4'hF, 32'h0);
    rd(TMR_COUNT, 32'h0, "ovf_count");
    rd(TMR_STAT,  32'h2, "ovf_stat");
    wr(TMR_STAT, 4'h1, 32'h7);
    wr(TMR_COUNT, 4'hF, 32'h1234_5678);
    wr(TMR_COUNT, 4'b0001, 32'h0000_00AA);
    rd(TMR_COUNT, 32'h1234_56AA, "byte_wr");

    // 4a: COUNT write in the same cycle as a tick
    wr(TMR_CTRL, 4'hF, 32'h1);
    wr(TMR_COUNT, 4'hF, 32'h1000);
    wr(TMR_CTRL, 4'hF, 32'h0);
    rd(TMR_COUNT, 32'h1001, "wr_vs_tick");

    // 4b: MATCH set in the same cycle as its W1C
    wr(TMR_CMP, 4'hF, 32'h20);
    wr(TMR_COUNT, 4'hF, 32'h1F);
    wr(TMR_CTRL, 4'hF, 32'h1);
    @(negedge clk);
    wr(TMR_STAT, 4'h1, 32'h1);
    wr(TMR_CTRL, 4'hF, 32'h0);
    rd(TMR_STAT,  32'h1,  "set_wins");
    rd(TMR_COUNT, 32'h22, "run_count");
    wr(TMR_STAT, 4'h1, 32'h7);

    // 5a: read with same-cycle write, rdy gating, CLR
    wr(TMR_COUNT, 4'hF, 32'h55);
    bus(TMR_COUNT, 4'hF, 1'b1, 32'h77, 32'h55, "rd_prewrite");
    rd(TMR_COUNT, 32'h77, "post_write");
    adr = TMR_COUNT; we = 4'hF; dw = 32'hDEAD; cs = 1'b1; rdy = 1'b0;
    @(negedge clk);
    cs = 1'b0; we = 4'h0; rdy = 1'b1;
    rd(TMR_COUNT, 32'h77, "rdy_gate");
    wr(TMR_CTRL, 4'h1, 32'h8);
    rd(TMR_COUNT, 32'h0, "clr_count");
    rd(TMR_CTRL,  32'h0, "clr_reads0");
    wr(TMR_CAP, 4'hF, 32'h1234);
    rd(TMR_CAP, 32'h0, "cap_ro");

    // 5b: reset while running with irq up
    wr(TMR_CMP, 4'hF, 32'h0);
    wr(TMR_CTRL, 4'hF, (32'd2 << 16) | 32'h7);
    repeat (5) @(negedge clk);
    chk("irq_pre_rst", {31'd0, irq}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("irq_post_rst", {31'd0, irq}, 32'h0);
    rd(TMR_CTRL,  32'h0,         "rst2_ctrl");
    rd(TMR_COUNT, 32'h0,         "rst2_count");
    rd(TMR_CMP,   32'hFFFF_FFFF, "rst2_cmp");
    rd(TMR_STAT,  32'h0,         "rst2_stat");

    // 6: capture
`ifdef RV_TIMER_CAPTURE_EN
    wr(TMR_CTRL, 4'hF, 32'h1);
    wr(TMR_COUNT, 4'hF, 32'd100);
    cap_in = 1'b1;
    rd(TMR_CAP, 32'h0, "cap_lat1");
    rd(TMR_CAP, 32'h0, "cap_lat2");
    wr(TMR_CTRL, 4'hF, 32'h0);
    cap_in = 1'b0;
    rd(TMR_CAP,  32'd102, "cap_val");
    rd(TMR_STAT, 32'h4,   "capf");
    wr(TMR_STAT, 4'h1, 32'h4);
    rd(TMR_STAT, 32'h0,   "capf_w1c");
`else
    wr(TMR_COUNT, 4'hF, 32'd100);
    rd(TMR_CAP,  32'h0, "nocap_cap");
    wr(TMR_STAT, 4'h1, 32'h4);
    rd(TMR_STAT, 32'h0, "nocap_stat");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
